dstm_select: RTL and testbench
==============================

Name: dstm_select

Overview:
- Decode-stage block that picks the memory-destination register (dstM) for the instruction in D.
- Only load instructions write a register from memory: dstM = rt for a load, else RNONE (5'd0).
- Provides the combinational d_dstM, the D->E pipeline copy E_dstM, and load-use hazard detection against the following instruction.

Parameters:
- OP_LW, 6'b100011, opcode of load word (ILW).
- OP_SW, 6'b101011, opcode of store word (ISW); never writes a register.
- OP_ADDI, 6'b001000, opcode of ADDI (IADDI); writes via dstE, not dstM.
- OP_RTYPE, 6'b000000, R-type opcode (IROP); writes via dstE, not dstM.
- RNONE, 5'd0, "no destination" encoding.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- D_op  input  6  opcode of the instruction in D.
- D_rt  input  5  rt field of the instruction in D.
- D_rs  input  5  rs field of the instruction in D (hazard compare).
- D_uses_rt  input  1  the instruction in D reads rt as a source.
- E_stall  input  1  hold the E register.
- E_bubble  input  1  load RNONE into the E register.
- d_dstM  output  5  combinational dstM of the D instruction.
- E_dstM  output  5  registered dstM of the E instruction.
- load_use  output  1  load-use hazard: the D instruction reads the register the E load writes.

Interface note: one clock; reset is asynchronous and active-low (clk, rst_n).

Behaviour:
- d_dstM is purely combinational, zero latency:
  - D_op == OP_LW -> D_rt.
  - All other opcodes, including SW, ADDI, R-type and unknown -> RNONE.
- E_dstM register:
  - rst_n low -> 5'd0 immediately (asynchronous).
  - Otherwise, on each rising clk edge:
    - E_bubble=1 -> RNONE. Bubble has priority over stall.
    - else E_stall=1 -> hold current value.
    - else -> d_dstM.
- load_use is combinational and asserted when E_dstM != RNONE and either:
  - E_dstM == D_rs, or
  - D_uses_rt=1 and E_dstM == D_rt.
- load_use is 0 during reset, because E_dstM = 0 = RNONE.
- Register 0 as a load target yields d_dstM = 0, which is indistinguishable from RNONE. This is intentional: writes to $0 are discarded and never raise a hazard.
- Reset asserted mid-operation clears E_dstM asynchronously. The first edge after reset release captures d_dstM normally.
- X/unknown D_op is treated as non-load.

Optional Feature:
- Macro DSTM_EXT_LOADS_EN.
- Defined: LB (6'b100000), LH (6'b100001), LBU (6'b100100) and LHU (6'b100101) are also loads, so d_dstM = D_rt for them.
- Undefined: only OP_LW is a load; these four opcodes give RNONE.

Test Plan:
- Reset and default opcode: rst_n=0 -> E_dstM=0 and load_use=0. Then D_op=0 (R-type), D_rt=0 -> d_dstM=0.
- Non-load opcodes with nonzero rt, each -> d_dstM=0:
  - D_op=OP_SW, D_rt=13.
  - D_op=OP_ADDI, D_rt=15.
  - D_op=OP_RTYPE, D_rt=3.
- Load opcode tracks rt combinationally:
  - D_op=OP_LW, D_rt=1 -> d_dstM=1.
  - Change D_rt to 5 -> d_dstM=5 in the same cycle.
- Pipeline controls:
  - LW rt=7, clock -> E_dstM=7.
  - E_stall=1 with a new D_rt=9, clock -> E_dstM stays 7.
  - E_bubble=1 and E_stall=1, clock -> E_dstM=0.
- Load-use detection, after E_dstM=7:
  - D_rs=7 -> load_use=1.
  - D_rs=2, D_rt=7, D_uses_rt=0 -> load_use=0.
  - Same with D_uses_rt=1 -> load_use=1.
  - LW to rt=0, then D_rs=0 -> load_use=0.
- Optional loads: D_op=6'b100000, D_rt=4 -> d_dstM=4 with DSTM_EXT_LOADS_EN defined, 0 without.

Source files
------------

// File: rtl/dstm_select.sv
// -----------------------------------------------------------------------------
// dstm_select
//
// Decode-stage selection of the memory-destination register (dstM). Only a
// load writes a register from memory, so dstM is the rt field for a load and
// RNONE for anything else. The block also keeps the D->E pipeline copy of
// dstM and flags a load-use hazard against the instruction now in D.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   D_op       opcode of the instruction in D
//   D_rt       rt field of the instruction in D
//   D_rs       rs field of the instruction in D
//   D_uses_rt  the D instruction reads rt as a source
//   E_stall    hold the E register
//   E_bubble   load RNONE into the E register (wins over E_stall)
//   d_dstM     combinational dstM of the D instruction
//   E_dstM     registered dstM of the E instruction
//   load_use   D instruction reads the register the E load is writing
//
// Optional feature:
//   DSTM_EXT_LOADS_EN  when defined, LB/LH/LBU/LHU are loads as well as LW.
// -----------------------------------------------------------------------------
module dstm_select #(
  parameter logic [5:0] OP_LW    = 6'b100011,
  parameter logic [5:0] OP_SW    = 6'b101011,
  parameter logic [5:0] OP_ADDI  = 6'b001000,
  parameter logic [5:0] OP_RTYPE = 6'b000000,
  parameter logic [4:0] RNONE    = 5'd0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] D_op,
  input  logic [4:0] D_rt,
  input  logic [4:0] D_rs,
  input  logic       D_uses_rt,
  input  logic       E_stall,
  input  logic       E_bubble,
  output logic [4:0] d_dstM,
  output logic [4:0] E_dstM,
  output logic       load_use
);

`ifdef DSTM_EXT_LOADS_EN
  localparam logic [5:0] OP_LB  = 6'b100000;
  localparam logic [5:0] OP_LH  = 6'b100001;
  localparam logic [5:0] OP_LBU = 6'b100100;
  localparam logic [5:0] OP_LHU = 6'b100101;
`endif

  logic [4:0] E_dstM_q;
  logic [4:0] E_dstM_d;

  // Stores, ADDI and R-type are listed explicitly so it is obvious they never
  // produce a memory destination; an unknown or X opcode lands in default.
  always_comb begin
    d_dstM = RNONE;
    case (D_op)
      OP_LW:                      d_dstM = D_rt;
`ifdef DSTM_EXT_LOADS_EN
      OP_LB, OP_LH, OP_LBU, OP_LHU: d_dstM = D_rt;
`endif
      OP_SW, OP_ADDI, OP_RTYPE:   d_dstM = RNONE;
      default:                    d_dstM = RNONE;
    endcase
  end

  // Bubble beats stall so a flushed slot is cleared even while E is held.
  always_comb begin
    E_dstM_d = d_dstM;
    if (E_bubble) begin
      E_dstM_d = RNONE;
    end else if (E_stall) begin
      E_dstM_d = E_dstM_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      E_dstM_q <= RNONE;
    end else begin
      E_dstM_q <= E_dstM_d;
    end
  end

  assign E_dstM = E_dstM_q;

  // A load to $0 shows up as RNONE, so it can never raise a hazard.
  assign load_use = (E_dstM_q != RNONE) &&
                    ((E_dstM_q == D_rs) || (D_uses_rt && (E_dstM_q == D_rt)));

endmodule

// File: tb/tb_dstm_select.sv
// -----------------------------------------------------------------------------
// tb_dstm_select
//
// Self-checking bench for dstm_select: directed cases followed by random
// traffic, compared against a reference model built from the load-opcode set
// and the bubble/stall/capture rules of the E register.
// -----------------------------------------------------------------------------
module tb_dstm_select;

  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_RTYPE = 6'b000000;

  logic       clk;
  logic       rst_n;
  logic [5:0] D_op;
  logic [4:0] D_rt;
  logic [4:0] D_rs;
  logic       D_uses_rt;
  logic       E_stall;
  logic       E_bubble;
  logic [4:0] d_dstM;
  logic [4:0] E_dstM;
  logic       load_use;

  int numChecks;
  int numFails;

  // Reference state: the dstM currently held by E, and the set of load opcodes.
  int         refE;
  logic [5:0] loadOps[$];

  dstm_select dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .D_op      (D_op),
    .D_rt      (D_rt),
    .D_rs      (D_rs),
    .D_uses_rt (D_uses_rt),
    .E_stall   (E_stall),
    .E_bubble  (E_bubble),
    .d_dstM    (d_dstM),
    .E_dstM    (E_dstM),
    .load_use  (load_use)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory destination of an instruction: its rt if the opcode is a load.
  function automatic int refDstM(input logic [5:0] op, input logic [4:0] rt);
    foreach (loadOps[i]) begin
      if (loadOps[i] === op) return int'(rt);
    end
    return 0;
  endfunction

  // Hazard when E holds a real destination that D reads.
  function automatic int refLoadUse();
    if (refE == 0) return 0;
    if (refE == int'(D_rs)) return 1;
    if (D_uses_rt && refE == int'(D_rt)) return 1;
    return 0;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    numChecks++;
    if (observed !== expected) begin
      numFails++;
      $display("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  // Drive D-stage inputs and check the combinational outputs.
  task automatic applyStimulus(input logic [5:0] op, input logic [4:0] rt,
                               input logic [4:0] rs, input logic usesRt,
                               input logic stall, input logic bubble,
                               input string tag);
    D_op      = op;
    D_rt      = rt;
    D_rs      = rs;
    D_uses_rt = usesRt;
    E_stall   = stall;
    E_bubble  = bubble;
    #1;
    checkOutput({tag, ".d_dstM"}, 32'(d_dstM), 32'(refDstM(op, rt)));
    checkOutput({tag, ".load_use"}, 32'(load_use), 32'(refLoadUse()));
  endtask

  // One rising edge: update the model from the inputs in effect, then check E.
  task automatic clockEdge(input string tag);
    @(posedge clk);
    if (E_bubble) refE = 0;
    else if (!E_stall) refE = refDstM(D_op, D_rt);
    @(negedge clk);
    #1;
    checkOutput({tag, ".E_dstM"}, 32'(E_dstM), 32'(refE));
    checkOutput({tag, ".load_use_after"}, 32'(load_use), 32'(refLoadUse()));
  endtask

  initial begin
    logic [5:0] rndOp;
    numChecks = 0;
    numFails  = 0;
    refE      = 0;
    loadOps   = {OP_LW};
`ifdef DSTM_EXT_LOADS_EN
    loadOps.push_back(6'b100000);
    loadOps.push_back(6'b100001);
    loadOps.push_back(6'b100100);
    loadOps.push_back(6'b100101);
`endif

    // Reset with a load to a nonzero register sitting in D.
    rst_n = 1'b0;
    D_op = OP_LW; D_rt = 5'd9; D_rs = 5'd9; D_uses_rt = 1'b1;
    E_stall = 1'b0; E_bubble = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset.E_dstM", 32'(E_dstM), 32'd0);
    checkOutput("reset.load_use", 32'(load_use), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    applyStimulus(OP_RTYPE, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, "rtype0");
    applyStimulus(OP_SW,    5'd13, 5'd1, 1'b0, 1'b0, 1'b0, "sw13");
    applyStimulus(OP_ADDI,  5'd15, 5'd1, 1'b0, 1'b0, 1'b0, "addi15");
    applyStimulus(OP_RTYPE, 5'd3,  5'd1, 1'b0, 1'b0, 1'b0, "rtype3");
    applyStimulus(OP_LW,    5'd1,  5'd2, 1'b0, 1'b0, 1'b0, "lw1");
    applyStimulus(OP_LW,    5'd5,  5'd2, 1'b0, 1'b0, 1'b0, "lw5");

    applyStimulus(OP_LW, 5'd7, 5'd2, 1'b0, 1'b0, 1'b0, "lw7");
    clockEdge("lw7");
    checkOutput("lw7.E_is_7", 32'(E_dstM), 32'd7);
    applyStimulus(OP_LW, 5'd9, 5'd2, 1'b0, 1'b1, 1'b0, "stall9");
    clockEdge("stall9");
    checkOutput("stall9.E_held_7", 32'(E_dstM), 32'd7);

    applyStimulus(OP_RTYPE, 5'd1, 5'd7, 1'b0, 1'b1, 1'b0, "hz_rs");
    checkOutput("hz_rs.direct", 32'(load_use), 32'd1);
    applyStimulus(OP_RTYPE, 5'd7, 5'd2, 1'b0, 1'b1, 1'b0, "hz_rt_unused");
    checkOutput("hz_rt_unused.direct", 32'(load_use), 32'd0);
    applyStimulus(OP_RTYPE, 5'd7, 5'd2, 1'b1, 1'b1, 1'b0, "hz_rt_used");
    checkOutput("hz_rt_used.direct", 32'(load_use), 32'd1);

    applyStimulus(OP_LW, 5'd9, 5'd2, 1'b0, 1'b1, 1'b1, "bubble");
    clockEdge("bubble");
    checkOutput("bubble.E_is_0", 32'(E_dstM), 32'd0);

    applyStimulus(OP_LW, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, "lw_r0");
    clockEdge("lw_r0");
    applyStimulus(OP_RTYPE, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, "r0_no_hazard");
    checkOutput("r0_no_hazard.direct", 32'(load_use), 32'd0);

    applyStimulus(6'b100000, 5'd4, 5'd1, 1'b0, 1'b0, 1'b0, "lb4");
`ifdef DSTM_EXT_LOADS_EN
    checkOutput("lb4.direct", 32'(d_dstM), 32'd4);
`else
    checkOutput("lb4.direct", 32'(d_dstM), 32'd0);
`endif

    // Random traffic biased toward loads and small register numbers.
    for (int n = 0; n < 400; n++) begin
      case ($urandom_range(0, 8))
        0, 1, 2: rndOp = OP_LW;
        3:       rndOp = OP_SW;
        4:       rndOp = OP_ADDI;
        5:       rndOp = OP_RTYPE;
        6:       rndOp = 6'b100000 | 6'($urandom_range(0, 1)) | (6'($urandom_range(0, 1)) << 2);
        default: rndOp = 6'($urandom);
      endcase
      applyStimulus(rndOp, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                    1'($urandom), 1'($urandom_range(0, 3) == 0),
                    1'($urandom_range(0, 5) == 0), "rand");
      clockEdge("rand");
    end

    // Reset asserted mid-cycle clears E without waiting for a clock edge.
    applyStimulus(OP_LW, 5'd12, 5'd1, 1'b0, 1'b0, 1'b0, "pre_rst");
    clockEdge("pre_rst");
    #2;
    rst_n = 1'b0;
    refE  = 0;
    #1;
    checkOutput("midrst.E_dstM", 32'(E_dstM), 32'd0);
    checkOutput("midrst.load_use", 32'(load_use), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(OP_LW, 5'd21, 5'd1, 1'b0, 1'b0, 1'b0, "post_rst");
    clockEdge("post_rst");
    checkOutput("post_rst.E_is_21", 32'(E_dstM), 32'd21);

    $display("End of test - %0d assertions evaluated, %0d failures", numChecks, numFails);
    $finish;
  end

  // Safety net so the run always ends.
  initial begin
    #200000;
    $display("[TB] FAIL timeout: observed running expected finished");
    $fatal(1, "[TB] timeout");
  end

endmodule
